// File: rtl/sik_fetch.sv
// SIK instruction fetch: streams imem words into a prefetch queue tagged with their PC.
// Optional pre-word folding is enabled by defining SIK_FETCH_PREFOLD_EN.
module sik_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_ir,
  output logic [15:0] out_pc,
  output logic        out_pre_valid,
  output logic [3:0]  out_pre
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic          drop_q, drop_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] occupancy;

  logic [15:0]   ir_mem_q [DEPTH];
  logic [15:0]   pc_mem_q [DEPTH];

  logic          resp, enq, deq, is_pre;

  // The outstanding read is counted so a full queue never over-issues.
  assign occupancy = count_q + CW'(inflight_q);
  assign imem_req  = !reset && !halt && !redirect && (occupancy < CW'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign resp      = inflight_q && !drop_q;
  assign out_valid = (count_q != '0);
  assign deq       = out_valid && out_ready && !redirect;
  assign enq       = resp && !redirect && !is_pre;

  assign out_ir    = ir_mem_q[head_q];
  assign out_pc    = pc_mem_q[head_q];

`ifdef SIK_FETCH_PREFOLD_EN
  logic          pre_pending_q, pre_pending_d;
  logic [3:0]    pre_val_q, pre_val_d;
  logic          prev_mem_q [DEPTH];
  logic [3:0]    pre_mem_q  [DEPTH];

  assign is_pre        = (imem_rdata[15:12] == 4'b0011);
  assign out_pre_valid = prev_mem_q[head_q];
  assign out_pre       = pre_mem_q[head_q];

  always_comb begin
    pre_pending_d = pre_pending_q;
    pre_val_d     = pre_val_q;
    if (redirect) begin
      pre_pending_d = 1'b0;
    end else if (resp && is_pre) begin
      pre_pending_d = 1'b1;
      pre_val_d     = imem_rdata[11:8];
    end else if (enq) begin
      pre_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_pending_q <= 1'b0;
      pre_val_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        prev_mem_q[i] <= 1'b0;
        pre_mem_q[i]  <= '0;
      end
    end else begin
      pre_pending_q <= pre_pending_d;
      pre_val_q     <= pre_val_d;
      if (enq) begin
        prev_mem_q[tail_q] <= pre_pending_q;
        pre_mem_q[tail_q]  <= pre_val_q;
      end
    end
  end
`else
  assign is_pre        = 1'b0;
  assign out_pre_valid = 1'b0;
  assign out_pre       = '0;
`endif

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    drop_d        = 1'b0;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (redirect) begin
      // Redirect wins over enqueue, dequeue and any response arriving this edge.
      fetch_pc_d = redirect_pc;
      drop_d     = inflight_q;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + 16'd1;
        inflight_pc_d = fetch_pc_q;
      end
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      drop_q        <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ir_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      if (enq) begin
        ir_mem_q[tail_q] <= imem_rdata;
        pc_mem_q[tail_q] <= inflight_pc_q;
      end
    end
  end

endmodule
